// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard/stall controller:
//   - IF/ID control encodings (go on / flush / keep)
//   - width of the mul/div busy counter
//   - the load-tracking slot record {valid, dest} and a helper that tests a
//     slot against the two source registers of the instruction in ID
// Register addresses are carried at REG_AW_MAX bits inside slots; narrower
// register files zero-extend into this width.
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam logic [1:0] IF_ID_GO    = 2'b00;
    localparam logic [1:0] IF_ID_FLUSH = 2'b01;
    localparam logic [1:0] IF_ID_KEEP  = 2'b10;

    localparam int MD_CW      = 4;
    localparam int REG_AW_MAX = 8;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] dest;
    } load_slot_t;

    // A slot raises a hazard only when it holds a load whose destination is a
    // real register (not $0) and matches either source of the ID instruction.
    function automatic logic slot_hits(input load_slot_t            s,
                                       input logic [REG_AW_MAX-1:0] rs,
                                       input logic [REG_AW_MAX-1:0] rt);
        return s.valid && (s.dest != '0) && ((s.dest == rs) || (s.dest == rt));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_tracker.sv
// -----------------------------------------------------------------------------
// md_busy_tracker
// Tracks the multi-cycle mul/div unit. A mul/div leaving ID/EX loads the
// counter with MD_LAT-1; the counter then counts down to zero. A new issue
// while busy reloads it.
// Ports:
//   clk, reset      pipeline clock, asynchronous active-high reset
//   id_ex_md        ID/EX holds a mul/div
//   if_id_hilo_use  instruction in ID reads HI/LO or is a mul/div
//   md_busy         counter nonzero
//   md_hz           ID instruction must wait for HI/LO
// -----------------------------------------------------------------------------
module md_busy_tracker
    import hazard_pkg::*;
#(
    parameter int MD_LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic id_ex_md,
    input  logic if_id_hilo_use,
    output logic md_busy,
    output logic md_hz
);

    localparam logic [MD_CW-1:0] RELOAD = MD_CW'(MD_LAT - 1);
    localparam logic [MD_CW-1:0] ONE    = MD_CW'(1);

    logic [MD_CW-1:0] cnt_q;
    logic [MD_CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (id_ex_md) begin
            cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign md_busy = (cnt_q != '0);
    // The issuing cycle itself (mul/div still in ID/EX) already blocks a
    // HI/LO consumer; the counter covers the remaining MD_LAT-1 cycles.
    assign md_hz   = if_id_hilo_use && (id_ex_md || md_busy);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Stateful hazard/stall controller for the 5-stage pipeline. Tracks in-flight
// loads across LOAD_STAGES post-ID stages and the mul/div unit's busy window,
// then drives PC keep, IF/ID go/flush/keep and the ID/EX bubble.
// Priority: reset > stall (load or HI/LO hazard) > taken branch > jump.
// Optional feature macro: HAZARD_STATS_EN (saturating stall-cycle counter on
// stall_cycles; tied to 0 when the macro is undefined).
// Ports:
//   clk, reset                 pipeline clock, asynchronous active-high reset
//   id_ex_memread, id_ex_rt    load in ID/EX and its destination
//   if_id_rs, if_id_rt         sources of the instruction in ID
//   id_ex_md                   mul/div in ID/EX
//   if_id_hilo_use             ID instruction reads HI/LO or is a mul/div
//   dobranch, dojump           control-transfer resolved this cycle
//   pckeep                     hold PC
//   control_if_id              00 go on, 01 flush, 10 keep
//   flush_id_ex                insert bubble into ID/EX
//   md_busy                    mul/div counter nonzero
//   stall_cycles               stall statistics
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int LOAD_STAGES = 1,
    parameter int MD_LAT      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_ex_memread,
    input  logic [REG_AW-1:0] id_ex_rt,
    input  logic [REG_AW-1:0] if_id_rs,
    input  logic [REG_AW-1:0] if_id_rt,
    input  logic              id_ex_md,
    input  logic              if_id_hilo_use,
    input  logic              dobranch,
    input  logic              dojump,
    output logic              pckeep,
    output logic [1:0]        control_if_id,
    output logic              flush_id_ex,
    output logic              md_busy,
    output logic [31:0]       stall_cycles
);

    logic [REG_AW_MAX-1:0] rs_x;
    logic [REG_AW_MAX-1:0] rt_x;
    logic [REG_AW_MAX-1:0] dest_x;
    load_slot_t            live_slot;
    logic                  chain_hz;
    logic                  load_hz;
    logic                  md_hz;
    logic                  stall;

    always_comb begin
        rs_x                 = '0;
        rt_x                 = '0;
        dest_x               = '0;
        rs_x[REG_AW-1:0]     = if_id_rs;
        rt_x[REG_AW-1:0]     = if_id_rt;
        dest_x[REG_AW-1:0]   = id_ex_rt;
        live_slot.valid      = id_ex_memread;
        live_slot.dest       = dest_x;
    end

    // Slot 0 is the live ID/EX pair; older slots follow it down a shift chain
    // so that a load stays visible for LOAD_STAGES cycles while IF/ID is held
    // and bubbles are fed into ID/EX behind it.
    generate
        if (LOAD_STAGES > 1) begin : g_chain
            localparam int N = LOAD_STAGES - 1;

            load_slot_t chain_q [N];
            load_slot_t chain_d [N];

            always_comb begin
                chain_d[0] = live_slot;
                for (int k = 1; k < N; k++) begin
                    chain_d[k] = chain_q[k-1];
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < N; k++) begin
                        chain_q[k] <= '0;
                    end
                end else begin
                    for (int k = 0; k < N; k++) begin
                        chain_q[k] <= chain_d[k];
                    end
                end
            end

            always_comb begin
                chain_hz = 1'b0;
                for (int k = 0; k < N; k++) begin
                    chain_hz = chain_hz | slot_hits(chain_q[k], rs_x, rt_x);
                end
            end
        end else begin : g_no_chain
            assign chain_hz = 1'b0;
        end
    endgenerate

    assign load_hz = slot_hits(live_slot, rs_x, rt_x) || chain_hz;

    md_busy_tracker #(
        .MD_LAT (MD_LAT)
    ) u_md (
        .clk            (clk),
        .reset          (reset),
        .id_ex_md       (id_ex_md),
        .if_id_hilo_use (if_id_hilo_use),
        .md_busy        (md_busy),
        .md_hz          (md_hz)
    );

    assign stall = load_hz || md_hz;

    // A stall wins over branch/jump; the resolving instruction is held and
    // resolves again once the stall clears.
    always_comb begin
        pckeep        = 1'b0;
        control_if_id = IF_ID_GO;
        flush_id_ex   = 1'b0;
        if (reset) begin
            pckeep        = 1'b0;
            control_if_id = IF_ID_GO;
            flush_id_ex   = 1'b0;
        end else if (stall) begin
            pckeep        = 1'b1;
            control_if_id = IF_ID_KEEP;
            flush_id_ex   = 1'b1;
        end else if (dobranch) begin
            control_if_id = IF_ID_FLUSH;
            flush_id_ex   = 1'b1;
        end else if (dojump) begin
            control_if_id = IF_ID_FLUSH;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       id_ex_memread;
    logic [4:0] id_ex_rt;
    logic [4:0] if_id_rs;
    logic [4:0] if_id_rt;
    logic       id_ex_md;
    logic       if_id_hilo_use;
    logic       dobranch;
    logic       dojump;

    logic        pk3, fl3, mb3, pk1, fl1, mb1;
    logic [1:0]  ci3, ci1;
    logic [31:0] sc3, sc1;

    int total = 0;
    int bad   = 0;

    // dut3: LOAD_STAGES=3, MD_LAT=4 ; dut1: LOAD_STAGES=1, MD_LAT=1
    pipe_hazard_ctrl #(.REG_AW(5), .LOAD_STAGES(3), .MD_LAT(4)) dut3 (
        .clk(clk), .reset(reset), .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .id_ex_md(id_ex_md),
        .if_id_hilo_use(if_id_hilo_use), .dobranch(dobranch), .dojump(dojump),
        .pckeep(pk3), .control_if_id(ci3), .flush_id_ex(fl3), .md_busy(mb3),
        .stall_cycles(sc3)
    );

    pipe_hazard_ctrl #(.REG_AW(5), .LOAD_STAGES(1), .MD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .id_ex_md(id_ex_md),
        .if_id_hilo_use(if_id_hilo_use), .dobranch(dobranch), .dojump(dojump),
        .pckeep(pk1), .control_if_id(ci1), .flush_id_ex(fl1), .md_busy(mb1),
        .stall_cycles(sc1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk3(input string nm, input logic pk, input logic [1:0] ci, input logic fl);
        chk({nm, " d3.pckeep"}, {31'd0, pk3}, {31'd0, pk});
        chk({nm, " d3.ctrl"}, {30'd0, ci3}, {30'd0, ci});
        chk({nm, " d3.flush"}, {31'd0, fl3}, {31'd0, fl});
    endtask

    task automatic chk1(input string nm, input logic pk, input logic [1:0] ci, input logic fl);
        chk({nm, " d1.pckeep"}, {31'd0, pk1}, {31'd0, pk});
        chk({nm, " d1.ctrl"}, {30'd0, ci1}, {30'd0, ci});
        chk({nm, " d1.flush"}, {31'd0, fl1}, {31'd0, fl});
    endtask

    task automatic set_in(input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                          input logic [4:0] rtid, input logic md, input logic hilo,
                          input logic br, input logic jp);
        id_ex_memread  = mr;
        id_ex_rt       = rt;
        if_id_rs       = rs;
        if_id_rt       = rtid;
        id_ex_md       = md;
        if_id_hilo_use = hilo;
        dobranch       = br;
        dojump         = jp;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves time at posedge+1 with reset released and all inputs idle.
    task automatic pulse_reset();
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        logic       v;
        logic [4:0] d;
    } rec_t;

    rec_t hist[$];   // loads seen in ID/EX on previous cycles, newest first
    int   md_since;  // cycles elapsed since a mul/div last left ID/EX
    bit   md_seen;

    function automatic void model_clear();
        hist.delete();
        md_seen  = 1'b0;
        md_since = 0;
    endfunction

    function automatic bit hit(input logic v, input logic [4:0] d);
        return v && (d != 5'd0) && ((d == if_id_rs) || (d == if_id_rt));
    endfunction

    function automatic void model_out(input int ls, input int ml, output logic pk,
                                      output logic [1:0] ci, output logic fl,
                                      output logic mb);
        bit lh, busy, st;
        lh = hit(id_ex_memread, id_ex_rt);
        for (int k = 0; k < ls - 1 && k < hist.size(); k++)
            if (hit(hist[k].v, hist[k].d)) lh = 1'b1;
        busy = md_seen && (md_since <= ml - 1);
        st   = lh || (if_id_hilo_use && (id_ex_md || busy));
        pk = 1'b0; ci = 2'b00; fl = 1'b0;
        mb = reset ? 1'b0 : busy;
        if (reset) begin
            pk = 1'b0;
        end else if (st) begin
            pk = 1'b1; ci = 2'b10; fl = 1'b1;
        end else if (dobranch) begin
            ci = 2'b01; fl = 1'b1;
        end else if (dojump) begin
            ci = 2'b01;
        end
    endfunction

    function automatic void model_edge();
        rec_t r;
        if (reset) begin
            model_clear();
        end else begin
            r.v = id_ex_memread;
            r.d = id_ex_rt;
            hist.push_front(r);
            if (hist.size() > 2) void'(hist.pop_back());
            if (id_ex_md) begin
                md_seen  = 1'b1;
                md_since = 1;
            end else if (md_seen && md_since < 100) begin
                md_since++;
            end
        end
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       mr;
        logic [4:0] rt, rs, rtid;
        logic       md, hilo, br, jp;
        logic       pk;
        logic [1:0] ci;
        logic       fl;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic epk, efl, emb;
        logic [1:0] eci;

        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0};
        tbl[1]  = '{1, 8, 8, 0, 0, 0, 0, 0, 1, 2'b10, 1};
        tbl[2]  = '{1, 8, 3, 8, 0, 0, 0, 0, 1, 2'b10, 1};
        tbl[3]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0};
        tbl[4]  = '{0, 8, 8, 0, 0, 0, 0, 0, 0, 2'b00, 0};
        tbl[5]  = '{1, 9, 8, 7, 0, 0, 0, 0, 0, 2'b00, 0};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b01, 1};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b01, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b01, 1};
        tbl[9]  = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 2'b10, 1};
        tbl[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0};
        tbl[11] = '{1, 5, 5, 0, 0, 0, 1, 1, 1, 2'b10, 1};

        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk3("reset", 0, 2'b00, 0);
        chk("reset d3.md_busy", {31'd0, mb3}, 32'd0);
        chk("reset d3.stall_cycles", sc3, 32'd0);
        tick();

        for (int i = 0; i < 12; i++) begin
            pulse_reset();
            set_in(tbl[i].mr, tbl[i].rt, tbl[i].rs, tbl[i].rtid,
                   tbl[i].md, tbl[i].hilo, tbl[i].br, tbl[i].jp);
            #1;
            chk3($sformatf("vec%0d", i), tbl[i].pk, tbl[i].ci, tbl[i].fl);
            chk1($sformatf("vec%0d", i), tbl[i].pk, tbl[i].ci, tbl[i].fl);
            tick();
        end

        // Load-use: lw $8 then consumer of $8; bubbles follow the load.
        pulse_reset();
        set_in(1, 8, 8, 0, 0, 0, 0, 0);
        #1; chk3("lu c0", 1, 2'b10, 1); chk1("lu c0", 1, 2'b10, 1);
        tick();
        set_in(0, 0, 8, 0, 0, 0, 0, 0);
        #1; chk3("lu c1", 1, 2'b10, 1); chk1("lu c1", 0, 2'b00, 0);
        tick();
        #1; chk3("lu c2", 1, 2'b10, 1); chk1("lu c2", 0, 2'b00, 0);
        tick();
        #1; chk3("lu c3", 0, 2'b00, 0);
        tick();

        // Load to $0 never stalls, even as it moves down the chain.
        pulse_reset();
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        #1; chk3("ld0 c0", 0, 2'b00, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #1; chk3("ld0 c1", 0, 2'b00, 0);
        tick();
        #1; chk3("ld0 c2", 0, 2'b00, 0);
        tick();

        // mult then mfhi: 4 stall cycles on dut3, 1 on dut1.
        pulse_reset();
        set_in(0, 0, 0, 0, 1, 1, 0, 0);
        #1; chk3("md c0", 1, 2'b10, 1); chk1("md c0", 1, 2'b10, 1);
        chk("md c0 d3.md_busy", {31'd0, mb3}, 32'd0);
        tick();
        set_in(0, 0, 0, 0, 0, 1, 0, 0);
        for (int c = 1; c <= 3; c++) begin
            #1;
            chk3($sformatf("md c%0d", c), 1, 2'b10, 1);
            chk($sformatf("md c%0d d3.md_busy", c), {31'd0, mb3}, 32'd1);
            chk1($sformatf("md c%0d", c), 0, 2'b00, 0);
            chk($sformatf("md c%0d d1.md_busy", c), {31'd0, mb1}, 32'd0);
            tick();
        end
        #1; chk3("md c4", 0, 2'b00, 0);
        chk("md c4 d3.md_busy", {31'd0, mb3}, 32'd0);
        tick();

        // Stall beats branch; then branch alone, then jump alone.
        pulse_reset();
        set_in(1, 8, 8, 0, 0, 0, 1, 0);
        #1; chk3("lhz+br", 1, 2'b10, 1);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        #1; chk3("br", 0, 2'b01, 1);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        #1; chk3("jp", 0, 2'b01, 0);
        tick();

        // Reset in the second cycle of a mul/div stall.
        pulse_reset();
        set_in(0, 0, 0, 0, 1, 1, 0, 0);
        #1; tick();
        set_in(0, 0, 0, 0, 0, 1, 0, 0);
        #1; chk3("rst c1", 1, 2'b10, 1);
        reset = 1'b1;
        #1; chk3("rst mid", 0, 2'b00, 0);
        chk("rst mid d3.md_busy", {31'd0, mb3}, 32'd0);
        tick();
        reset = 1'b0;
        #1; chk3("rst after", 0, 2'b00, 0);
        chk("rst after d3.md_busy", {31'd0, mb3}, 32'd0);
        tick();

`ifdef HAZARD_STATS_EN
        pulse_reset();
        set_in(1, 8, 8, 0, 0, 0, 0, 0);
        for (int c = 0; c < 5; c++) tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #1; chk("stats five", sc3, 32'd5);
        tick(); tick(); tick();
        dut3.stall_cycles_q = 32'hFFFF_FFFE;
        set_in(1, 8, 8, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #1; chk("stats saturate", sc3, 32'hFFFF_FFFF);
        tick();
`else
        chk("stats tied d3", sc3, 32'd0);
        chk("stats tied d1", sc1, 32'd0);
`endif

        // Randomized run against the reference model.
        pulse_reset();
        model_clear();
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            set_in($urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
                   $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) == 0));
            if (reset) model_clear();
            #1;
            model_out(3, 4, epk, eci, efl, emb);
            chk3($sformatf("rnd%0d", n), epk, eci, efl);
            chk($sformatf("rnd%0d d3.md_busy", n), {31'd0, mb3}, {31'd0, emb});
            model_out(1, 1, epk, eci, efl, emb);
            chk1($sformatf("rnd%0d", n), epk, eci, efl);
            chk($sformatf("rnd%0d d1.md_busy", n), {31'd0, mb1}, {31'd0, emb});
            model_edge();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and stall controller for the 5-stage pipeline, sitting between the IF/ID, ID/EX and PC registers and driving their keep/flush controls. It tracks in-flight loads over a configurable number of post-ID stages and tracks a multi-cycle mul/div unit with a busy counter, then issues stall, flush and keep decisions. Branch/jump flushing uses the established priority. Unlike the single-cycle combinational hazard check, it holds state across cycles.

## Interface
- REG_AW, 5, register address width
- LOAD_STAGES, 1, stages (starting at ID/EX) in which a load result is not yet forwardable; legal 1..3
- MD_LAT, 4, mul/div latency in cycles from leaving ID/EX to HI/LO valid; legal 1..15
- clk  in  1  pipeline clock
- reset  in  1  reset; asynchronous, active-high
- id_ex_memread  in  1  ID/EX holds a load
- id_ex_rt  in  REG_AW  load destination in ID/EX
- if_id_rs, if_id_rt  in  REG_AW each  source registers of the instruction in ID
- id_ex_md  in  1  ID/EX holds a mul/div
- if_id_hilo_use  in  1  instruction in ID reads HI/LO or is a mul/div
- dobranch  in  1  taken branch resolved this cycle
- dojump  in  1  j/jal/jr resolved this cycle
- pckeep  out  1  hold PC
- control_if_id  out  2  00 go on, 01 flush, 10 keep
- flush_id_ex  out  1  insert bubble into ID/EX
- md_busy  out  1  mul/div counter nonzero
- stall_cycles  out  32  stall statistics (only with HAZARD_STATS_EN)

## Operation
- Load tracking: slot 0 is the live pair {id_ex_memread, id_ex_rt}. Slots 1..LOAD_STAGES-1 form a registered shift chain. On every clk edge, slot k+1 takes slot k. Slot 1 takes {id_ex_memread, id_ex_rt}.
- load_hz: any valid slot whose dest is nonzero and equals if_id_rs or if_id_rt. Register 0 never raises a hazard.
- md counter (4 bit): on an edge with id_ex_md=1, load MD_LAT-1. Otherwise decrement if nonzero. A new issue while busy reloads the counter.
- md_busy = counter != 0.
- md_hz: if_id_hilo_use && (id_ex_md || md_busy).
- Priority is fixed, evaluated combinationally each cycle:
  - reset: all outputs 0 / 00.
  - load_hz || md_hz (stall): pckeep=1, control_if_id=10, flush_id_ex=1.
  - dobranch: pckeep=0, control_if_id=01, flush_id_ex=1.
  - dojump: pckeep=0, control_if_id=01, flush_id_ex=0.
  - Otherwise: 0, 00, 0.
- A stall coinciding with dobranch or dojump yields the stall. Branch/jump resolution re-occurs after the stall clears.

## Timing
- All control outputs are combinational from the inputs and registered state; zero-cycle latency.
- Load-use penalty for an immediately dependent instruction is LOAD_STAGES cycles. The bubble advances through the chain while IF/ID is held.
- Mul/div penalty for an immediate HI/LO consumer is MD_LAT cycles: 1 cycle on id_ex_md, then MD_LAT-1 cycles on the counter.
- Asserting reset at any time, including mid-stall, clears the chain and the counter immediately. Outputs go to the go-on values (0, 00, 0) while reset is high. The first cycle after release has no stall.
- MD_LAT=1: the counter never becomes nonzero, so md_busy stays 0.

## Configuration
- HAZARD_STATS_EN defined:
  - stall_cycles counts the cycles with the stall condition active.
  - The counter saturates at 32'hFFFF_FFFF.
  - It is cleared by reset.
- HAZARD_STATS_EN undefined:
  - The counter logic is absent.
  - stall_cycles is tied to 0.

## Structure
- hazard_pkg holds:
  - IF_ID_GO=2'b00, IF_ID_FLUSH=2'b01, IF_ID_KEEP=2'b10.
  - the md counter width constant MD_CW=4.
  - the load-slot typedef {valid, dest}.
- Sub-module md_busy_tracker: counter, md_busy, and the md_hz term. The load chain and the priority mux stay in the top.

## Test plan
- LOAD_STAGES=1; lw to $8 in ID/EX, ID reads rs=$8 → one cycle of pckeep=1, control_if_id=10, flush_id_ex=1, then go-on.
- LOAD_STAGES=3; same dependency → stall held exactly 3 cycles. With dest=$0 → no stall.
- MD_LAT=4; mult in ID/EX followed by mfhi in ID → 4 stall cycles. md_busy is high for cycles 2–4, then go-on.
- Load hazard plus dobranch in the same cycle → stall outputs. Later dobranch alone → 01/flush_id_ex=1. dojump alone → 01/flush_id_ex=0.
- Reset asserted in cycle 2 of an MD_LAT=4 stall → outputs 0/00/0 immediately. md_busy=0 after release; mfhi proceeds without stall.
- HAZARD_STATS_EN; 5 stall cycles → stall_cycles=5. Preload the counter near saturation → it holds at 32'hFFFF_FFFF.
